// File: rtl/lcd_bus_capture.sv
// Passive HD44780 bus receiver: decodes lcd_en strobes and keeps a 32-cell shadow of the display.
// Optional LCD_CAPTURE_CGRAM_EN adds a 64x5 CGRAM shadow and stretches the reset sweep to 64 cycles.
module lcd_bus_capture #(
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  input  logic [5:0] cg_rd_addr,
  output logic [4:0] cg_rd_data,
  output logic [6:0] cursor_addr,
  output logic       display_on,
  output logic       busy,
  output logic       cmd_valid,
  output logic       data_valid,
  output logic [7:0] last_byte,
  output logic       err_overrun,
  output logic       err_read
);

`ifdef LCD_CAPTURE_CGRAM_EN
  localparam logic [5:0] RST_LAST = 6'd63;
`else
  localparam logic [5:0] RST_LAST = 6'd31;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        clr_q, clr_d;
  logic        en_q, rs_q, rw_q;
  logic [7:0]  data_q;
  logic [6:0]  ac_q, ac_d;
  logic        mode_q, mode_d;
  logic        inc_q, inc_d;
  logic        disp_q, disp_d;
  logic        cmdv_q, cmdv_d, datv_q, datv_d;
  logic [7:0]  last_q, last_d;
  logic        ovr_q, ovr_d, rde_q, rde_d;
  logic [7:0]  rd_char_q;
  logic [7:0]  cells_q [32];
  logic        cell_we, cg_we;
  logic [4:0]  cell_idx;
  logic [7:0]  cell_wdata;
  logic        strobe;

  // AC step: CGRAM wraps mod 64; DDRAM follows the two-line 0x00-0x27 / 0x40-0x67 map.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic cg, input logic up);
    if (cg) return {1'b0, up ? ac[5:0] + 6'd1 : ac[5:0] - 6'd1};
    if (ac >= 7'h28 && ac <= 7'h3F) return 7'h40;
    if (ac >= 7'h68) return 7'h00;
    if (up) return (ac == 7'h27) ? 7'h40 : (ac == 7'h67) ? 7'h00 : ac + 7'd1;
    return (ac == 7'h00) ? 7'h67 : (ac == 7'h40) ? 7'h27 : ac - 7'd1;
  endfunction

  assign strobe = en_q & ~lcd_en;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_d      = clr_q;
    ac_d       = ac_q;
    mode_d     = mode_q;
    inc_d      = inc_q;
    disp_d     = disp_q;
    cmdv_d     = 1'b0;
    datv_d     = 1'b0;
    last_d     = last_q;
    ovr_d      = ovr_q;
    rde_d      = rde_q;
    cell_we    = 1'b0;
    cell_idx   = cnt_q[4:0];
    cell_wdata = FILL_CHAR;
    cg_we      = 1'b0;

    case (state_q)
      S_CLEAR: begin
        cell_we = ~cnt_q[5];
        if (cnt_q == (clr_q ? 6'd31 : RST_LAST)) begin
          state_d = clr_q ? S_DONE : S_IDLE;
          if (clr_q) begin
            ac_d   = 7'h00;
            inc_d  = 1'b1;
            mode_d = 1'b0;
            cmdv_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (strobe) begin
      if (rw_q) begin
        rde_d = 1'b1;
      end else if (state_q == S_CLEAR) begin
        ovr_d = 1'b1;
      end else begin
        last_d = data_q;
        if (rs_q) begin
          datv_d = 1'b1;
          if (!mode_q) begin
            // Only the 16 visible columns of each line are shadowed.
            cell_we    = (ac_q[6:4] == 3'b000) || (ac_q[6:4] == 3'b100);
            cell_idx   = {ac_q[6], ac_q[3:0]};
            cell_wdata = data_q;
          end else begin
            cg_we = 1'b1;
          end
          ac_d = ac_step(ac_q, mode_q, inc_q);
        end else begin
          cmdv_d = (data_q != 8'h01);
          casez (data_q)
            8'b1???????: begin ac_d = data_q[6:0]; mode_d = 1'b0; end
            8'b01??????: begin ac_d = {1'b0, data_q[5:0]}; mode_d = 1'b1; end
            8'b001?????: ;
            8'b0001????: if (!data_q[3]) ac_d = ac_step(ac_q, mode_q, data_q[2]);
            8'b00001???: disp_d = data_q[2];
            8'b000001??: inc_d = data_q[1];
            8'b0000001?: begin ac_d = 7'h00; mode_d = 1'b0; end
            8'b00000001: begin state_d = S_CLEAR; cnt_d = 6'd0; clr_d = 1'b1; end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    data_q <= lcd_data;
    rs_q   <= lcd_rs;
    rw_q   <= lcd_rw;
    if (rst) begin
      en_q      <= 1'b0;
      state_q   <= S_CLEAR;
      cnt_q     <= 6'd0;
      clr_q     <= 1'b0;
      ac_q      <= 7'h00;
      mode_q    <= 1'b0;
      inc_q     <= 1'b1;
      disp_q    <= 1'b0;
      cmdv_q    <= 1'b0;
      datv_q    <= 1'b0;
      last_q    <= 8'h00;
      ovr_q     <= 1'b0;
      rde_q     <= 1'b0;
      rd_char_q <= 8'h00;
    end else begin
      en_q      <= lcd_en;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_q     <= clr_d;
      ac_q      <= ac_d;
      mode_q    <= mode_d;
      inc_q     <= inc_d;
      disp_q    <= disp_d;
      cmdv_q    <= cmdv_d;
      datv_q    <= datv_d;
      last_q    <= last_d;
      ovr_q     <= ovr_d;
      rde_q     <= rde_d;
      rd_char_q <= cells_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (cell_we) cells_q[cell_idx] <= cell_wdata;
  end

`ifdef LCD_CAPTURE_CGRAM_EN
  logic [4:0] cg_q [64];
  logic [4:0] cg_rd_q;

  // Only the reset sweep (clr_q low) zeroes CGRAM; Clear Display leaves it alone.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR && !clr_q) cg_q[cnt_q] <= 5'd0;
    else if (cg_we) cg_q[ac_q[5:0]] <= data_q[4:0];
  end

  always_ff @(posedge clk) begin
    if (rst) cg_rd_q <= 5'd0;
    else     cg_rd_q <= cg_q[cg_rd_addr];
  end

  assign cg_rd_data = cg_rd_q;
`else
  logic unused_cg;
  assign unused_cg  = (^cg_rd_addr) ^ cg_we;
  assign cg_rd_data = 5'd0;
`endif

  assign rd_char     = rd_char_q;
  assign cursor_addr = ac_q;
  assign display_on  = disp_q;
  assign busy        = (state_q == S_CLEAR);
  assign cmd_valid   = cmdv_q;
  assign data_valid  = datv_q;
  assign last_byte   = last_q;
  assign err_overrun = ovr_q;
  assign err_read    = rde_q;

endmodule

// File: tb/tb_lcd_bus_capture.sv
// Directed bench for lcd_bus_capture: drives HD44780 strobes and compares against hand-computed values.
module tb_lcd_bus_capture;

`ifdef LCD_CAPTURE_CGRAM_EN
  localparam int RST_SWEEP = 64;
`else
  localparam int RST_SWEEP = 32;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_en = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_char;
  logic [5:0] cg_rd_addr = 6'd0;
  logic [4:0] cg_rd_data;
  logic [6:0] cursor_addr;
  logic       display_on, busy, cmd_valid, data_valid, err_overrun, err_read;
  logic [7:0] last_byte;

  int checks = 0;
  int errors = 0;

  lcd_bus_capture dut (
    .clk(clk), .rst(rst), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_char(rd_char),
    .cg_rd_addr(cg_rd_addr), .cg_rd_data(cg_rd_data), .cursor_addr(cursor_addr),
    .display_on(display_on), .busy(busy), .cmd_valid(cmd_valid),
    .data_valid(data_valid), .last_byte(last_byte),
    .err_overrun(err_overrun), .err_read(err_read)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Returns just after the edge on which the strobe is decoded.
  task automatic send(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    lcd_en = 1'b1; lcd_rs = rs; lcd_rw = rw; lcd_data = d;
    @(negedge clk);
    lcd_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic read_cell(input logic [4:0] a, output logic [7:0] c);
    @(negedge clk);
    rd_addr = a;
    @(posedge clk); #1;
    c = rd_char;
  endtask

  task automatic read_cg(input logic [5:0] a, output logic [4:0] c);
    @(negedge clk);
    cg_rd_addr = a;
    @(posedge clk); #1;
    c = cg_rd_data;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_ac"}, cursor_addr, 7'h00);
    chk({tag, "_disp"}, display_on, 1'b0);
    chk({tag, "_cmdv"}, cmd_valid, 1'b0);
    chk({tag, "_datv"}, data_valid, 1'b0);
    chk({tag, "_last"}, last_byte, 8'h00);
    chk({tag, "_rdchar"}, rd_char, 8'h00);
    chk({tag, "_cgrd"}, cg_rd_data, 5'h00);
    chk({tag, "_ovr"}, err_overrun, 1'b0);
    chk({tag, "_rde"}, err_read, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] c;
    logic [4:0] g;
    logic [7:0] msg [9];
    msg = '{8'h47, 8'h41, 8'h4D, 8'h45, 8'h20, 8'h4F, 8'h56, 8'h45, 8'h52};

    repeat (3) @(posedge clk);
    #1;
    reset_values("rst");
    rst = 1'b0;
    busy_len(n);
    chk("rst_sweep_len", n, RST_SWEEP);
    chk("rst_sweep_cmdv", cmd_valid, 1'b0);

    send(1'b0, 1'b0, 8'h38);
    chk("fset_cmdv", cmd_valid, 1'b1);
    chk("fset_last", last_byte, 8'h38);
    send(1'b0, 1'b0, 8'h0C);
    chk("disp_on", display_on, 1'b1);
    send(1'b0, 1'b0, 8'h06);
    send(1'b0, 1'b0, 8'h01);
    chk("clr_cmdv_early", cmd_valid, 1'b0);
    busy_len(n);
    chk("clr_busy_len", n, 32);
    chk("clr_cmdv", cmd_valid, 1'b1);
    chk("clr_ac", cursor_addr, 7'h00);

    for (int i = 0; i < 9; i++) begin
      send(1'b1, 1'b0, msg[i]);
      chk("msg_datv", data_valid, 1'b1);
      chk("msg_cmdv", cmd_valid, 1'b0);
    end
    chk("msg_ac", cursor_addr, 7'h09);
    chk("msg_disp", display_on, 1'b1);
    for (int i = 0; i < 32; i++) begin
      read_cell(5'(i), c);
      chk($sformatf("msg_cell%0d", i), c, (i < 9) ? msg[i] : 8'h20);
    end

    send(1'b0, 1'b0, 8'hC0);
    chk("ddram40_ac", cursor_addr, 7'h40);
    send(1'b1, 1'b0, 8'h53);
    chk("s_ac", cursor_addr, 7'h41);
    read_cell(5'd16, c);
    chk("s_cell16", c, 8'h53);
    send(1'b0, 1'b0, 8'h8F);
    send(1'b1, 1'b0, 8'h41);
    send(1'b1, 1'b0, 8'h42);
    chk("ab_ac", cursor_addr, 7'h11);
    chk("ab_last", last_byte, 8'h42);
    read_cell(5'd15, c);
    chk("ab_cell15", c, 8'h41);
    read_cell(5'd16, c);
    chk("ab_cell16", c, 8'h53);

    send(1'b0, 1'b0, 8'h04);
    send(1'b0, 1'b0, 8'h80);
    send(1'b1, 1'b0, 8'h78);
    chk("dec_wrap00", cursor_addr, 7'h67);
    read_cell(5'd0, c);
    chk("dec_cell0", c, 8'h78);
    send(1'b0, 1'b0, 8'hC0);
    send(1'b1, 1'b0, 8'h79);
    chk("dec_wrap40", cursor_addr, 7'h27);
    send(1'b0, 1'b0, 8'h06);
    send(1'b0, 1'b0, 8'hA7);
    send(1'b1, 1'b0, 8'h7A);
    chk("inc_wrap27", cursor_addr, 7'h40);
    send(1'b0, 1'b0, 8'hB0);
    send(1'b1, 1'b0, 8'h7A);
    chk("inc_gap30", cursor_addr, 7'h40);
    send(1'b0, 1'b0, 8'hE7);
    send(1'b1, 1'b0, 8'h7A);
    chk("inc_wrap67", cursor_addr, 7'h00);
    send(1'b0, 1'b0, 8'h10);
    chk("shift_left", cursor_addr, 7'h67);
    send(1'b0, 1'b0, 8'h14);
    chk("shift_right", cursor_addr, 7'h00);
    chk("no_ovr_yet", err_overrun, 1'b0);
    chk("no_rde_yet", err_read, 1'b0);

    send(1'b0, 1'b0, 8'h01);
    send(1'b0, 1'b0, 8'hC5);
    chk("ovr_flag", err_overrun, 1'b1);
    chk("ovr_cmdv", cmd_valid, 1'b0);
    chk("ovr_busy", busy, 1'b1);
    busy_len(n);
    chk("ovr_last", last_byte, 8'h01);
    chk("ovr_ac", cursor_addr, 7'h00);
    send(1'b0, 1'b1, 8'hC5);
    chk("rde_flag", err_read, 1'b1);
    chk("rde_cmdv", cmd_valid, 1'b0);
    chk("rde_ac", cursor_addr, 7'h00);
    chk("rde_last", last_byte, 8'h01);

    send(1'b0, 1'b0, 8'hCF);
    send(1'b1, 1'b0, 8'h51);
    chk("q_ac", cursor_addr, 7'h50);
    read_cell(5'd31, c);
    chk("q_cell31", c, 8'h51);
    send(1'b0, 1'b0, 8'h01);
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    reset_values("mid");
    rst = 1'b0;
    busy_len(n);
    chk("mid_sweep_len", n, RST_SWEEP);
    chk("mid_cmdv", cmd_valid, 1'b0);
    for (int i = 0; i < 32; i++) begin
      read_cell(5'(i), c);
      chk($sformatf("mid_cell%0d", i), c, 8'h20);
    end

    send(1'b0, 1'b0, 8'h48);
    chk("cg_ac", cursor_addr, 7'h08);
    send(1'b1, 1'b0, 8'h1F);
    chk("cg_datv", data_valid, 1'b1);
    send(1'b1, 1'b0, 8'h11);
    chk("cg_ac_end", cursor_addr, 7'h0A);
    read_cell(5'd8, c);
    chk("cg_cell8", c, 8'h20);
    read_cg(6'd8, g);
`ifdef LCD_CAPTURE_CGRAM_EN
    chk("cg_rd8", g, 5'h1F);
`else
    chk("cg_rd8", g, 5'h00);
`endif
    read_cg(6'd9, g);
`ifdef LCD_CAPTURE_CGRAM_EN
    chk("cg_rd9", g, 5'h11);
`else
    chk("cg_rd9", g, 5'h00);
`endif
    read_cg(6'd10, g);
    chk("cg_rd10", g, 5'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_bus_capture.md
# lcd_bus_capture

Passive receiver for the 16x2 character-LCD bus (lcd_en, lcd_rs, lcd_rw, lcd_data) driven by the LCD writer block. It decodes each bus strobe as an HD44780 instruction or data write and maintains a 32-character shadow of the visible display, plus address counter and display state. It sits beside the LCD writer in the top level for on-board self-check and is the checking end for verifying the LCD messages (game over, success, time over).

## Interface
- FILL_CHAR, 8'h20, character written to every cell by reset and Clear Display
- clk  in  1  system clock (25 MHz); bus inputs are synchronous to it
- rst  in  1  synchronous, active-high reset
- lcd_en  in  1  bus enable strobe; a transfer is taken on its falling edge
- lcd_rs  in  1  0 = instruction, 1 = data
- lcd_rw  in  1  0 = write, 1 = read
- lcd_data  in  8  bus data
- rd_addr  in  5  shadow read index: 0-15 = line 1, 16-31 = line 2
- rd_char  out  8  registered shadow character at rd_addr
- cg_rd_addr  in  6  CGRAM read index
- cg_rd_data  out  5  registered CGRAM row at cg_rd_addr
- cursor_addr  out  7  current address counter (AC)
- display_on  out  1  D bit of last Display Control
- busy  out  1  high during Clear Display sweep
- cmd_valid  out  1  one-cycle pulse per accepted instruction
- data_valid  out  1  one-cycle pulse per accepted data write
- last_byte  out  8  byte of the most recent accepted transfer
- err_overrun  out  1  sticky: strobe arrived while busy
- err_read  out  1  sticky: strobe with lcd_rw=1

## Operation
- Inputs are registered once (en_q, rs_q, rw_q, data_q). A strobe is en_q=1 and lcd_en=0; the transfer uses rs_q/rw_q/data_q.
- rw_q=1: set err_read and drop.
- State machine: IDLE, CLEAR (sweep), DONE (pulse). A strobe in CLEAR sets err_overrun and is dropped.
- Instruction decode (rs_q=0), highest set bit wins:
  - 1aaaaaaa: Set DDRAM. AC=aaaaaaa, mode=DDRAM.
  - 01aaaaaa: Set CGRAM. AC=aaaaaa, mode=CGRAM.
  - 001xxxxx: Function Set. Accepted; no state change.
  - 0001 SC RL xx: if SC=0, AC moves +1 (RL=1) or -1 (RL=0) with DDRAM wrap rules. If SC=1, accepted with no effect.
  - 00001DCB: display_on=D.
  - 000001 ID S: inc=ID. S is ignored.
  - 0000001x: Return Home. AC=0, mode=DDRAM.
  - 00000001: Clear Display. Enter CLEAR, write FILL_CHAR to cells 0..31 one per cycle, then AC=0, inc=1, mode=DDRAM.
  - 00000000: accepted with no effect.
- Data write (rs_q=1), DDRAM mode:
  - AC 0x00-0x0F writes cell AC; AC 0x40-0x4F writes cell 16+(AC-0x40).
  - Any other AC: accepted, no cell written.
  - AC then steps per inc.
- DDRAM AC wrap:
  - Increment: 0x27 -> 0x40, 0x67 -> 0x00.
  - Decrement: 0x00 -> 0x67, 0x40 -> 0x27.
  - Set DDRAM to 0x28-0x3F or 0x68-0x7F is stored as given; the next step maps 0x28-0x3F to 0x40 and 0x68-0x7F to 0x00.
- CGRAM mode: AC is 6 bits and wraps mod 64. The data write itself is defined under Configuration.
- cmd_valid and data_valid pulse, and last_byte updates, on every accepted transfer. A dropped transfer produces neither.

## Timing
- Strobe decode and register update take effect in the cycle after lcd_en is seen low. cmd_valid/data_valid are high in that same cycle.
- Clear Display: busy goes high the cycle after the strobe and stays high for exactly 32 cycles. cmd_valid pulses in the cycle busy falls.
- rd_char and cg_rd_data have 1-cycle read latency. A same-cycle write to the addressed cell is visible on the next read.
- A strobe in the final CLEAR cycle is dropped with err_overrun.
- Reset, including mid-sweep, gives:
  - all 32 cells = FILL_CHAR; reset runs its own 32-cycle sweep with busy=1
  - AC=0, inc=1, mode=DDRAM, display_on=0
  - pulses=0, last_byte=0, rd_char=0, cg_rd_data=0, both errors=0

## Configuration
- LCD_CAPTURE_CGRAM_EN defined: 64x5 CGRAM array. A CGRAM-mode data write stores data_q[4:0] at AC. cg_rd_data reads it. Reset clears CGRAM to 0 during the reset sweep (64 cycles, busy=1).
- Undefined: no array. CGRAM-mode data writes only step AC and pulse data_valid. cg_rd_data is constant 0, and the reset sweep is 32 cycles.

## Test plan
- Reset, then strobes: 0x38, 0x0C, 0x06, 0x01, then "GAME OVER" as data -> busy 32 cycles; cells 0-8 = "GAME OVER", cells 9-31 = 8'h20, cursor_addr=0x09, display_on=1.
- Set DDRAM 0xC0 (AC=0x40), then write 'S' -> cell 16='S', cursor_addr=0x41. Then Set DDRAM 0x8F (AC=0x0F), write 'A','B' -> cell 15='A', 'B' not stored, cursor_addr=0x11.
- Wrap checks:
  - Entry mode 0x04 (decrement), AC=0x00, one write -> cursor_addr=0x67.
  - Increment mode, AC=0x27, one write -> cursor_addr=0x40.
- Second strobe 3 cycles after 0x01 -> err_overrun=1 and dropped. Strobe with lcd_rw=1 -> err_read=1, no cmd_valid.
- Assert rst mid-sweep at cycle 10 of Clear -> all outputs take reset values and all cells read 8'h20 after the sweep.
- With LCD_CAPTURE_CGRAM_EN defined: 0x48, then data 0x1F, 0x11 -> cg_rd_data[8]=5'h1F, [9]=5'h11. Without it: cg_rd_data=0 and cursor_addr=0x0A.
